// File: rtl/systolic_result_drain_if.sv
// Row-stream interface of systolic_result_drain.
// master: the drain block (takes the capture request and the accumulator bus, drives the row stream).
// slave : the host/consumer side.
interface systolic_result_drain_if #(
  parameter int N    = 4,
  parameter int Accw = 32
);
  logic                   start;
  logic [N*N*Accw-1:0]    acc_in;
  logic                   acc_clr;
  logic                   busy;
  logic                   row_valid;
  logic                   row_ready;
  logic [N*Accw-1:0]      row_data;
  logic [$clog2(N)-1:0]   row_idx;
  logic                   row_last;
  logic                   done;
  logic                   drop;

  modport master (
    input  start, acc_in, row_ready,
    output acc_clr, busy, row_valid, row_data, row_idx, row_last, done, drop
  );

  modport slave (
    output start, acc_in, row_ready,
    input  acc_clr, busy, row_valid, row_data, row_idx, row_last, done, drop
  );
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the N*N accumulator bus of a systolic array on
// start, then streams the snapshot one row per valid/ready beat.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN: clamp negative elements to 0 at capture
// (fused ReLU). Without it elements are passed through unchanged.
module systolic_result_drain #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int Accw = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_result_drain_if.master bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [IW-1:0]        cnt_reg, cnt_next;
  logic                 first_reg;
  logic                 capture;
  logic [N*N*Accw-1:0]  cap_flat;
  logic [N*Accw-1:0]    snap_reg [N];

  // W only documents the operand width of the feeding array; reject nonsense configs.
  if (N < 2 || W < 1 || Accw < 1) begin : g_cfg_check
    $error("systolic_result_drain: illegal parameters");
  end

  // Per-element capture value: optional clamp of negative accumulators.
  for (genvar gi = 0; gi < N*N; gi++) begin : g_cap
    logic [Accw-1:0] raw;
    assign raw = bus.acc_in[gi*Accw +: Accw];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign cap_flat[gi*Accw +: Accw] = raw[Accw-1] ? '0 : raw;
`else
    assign cap_flat[gi*Accw +: Accw] = raw;
`endif
  end

  // Snapshot store, one row per entry; written only on an accepted capture.
  always_ff @(posedge clk) begin
    if (rst && capture) begin
      for (int r = 0; r < N; r++) begin
        snap_reg[r] <= cap_flat[r*N*Accw +: N*Accw];
      end
    end
  end

  // State, row counter and first-cycle flag (which generates acc_clr).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      first_reg <= capture;
    end
  end

  // Next-state logic and all stream/status outputs.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.busy      = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.row_idx   = cnt_reg;
    bus.row_last  = 1'b0;
    bus.done      = 1'b0;
    bus.drop      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        bus.busy      = 1'b1;
        bus.row_valid = 1'b1;
        bus.acc_clr   = first_reg;
        bus.row_data  = snap_reg[cnt_reg];
        bus.row_last  = (cnt_reg == IW'(N-1));
        bus.drop      = bus.start;
        if (bus.row_ready) begin
          if (cnt_reg == IW'(N-1)) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + IW'(1);
          end
        end
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        bus.drop   = bus.start;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain (N=4, Accw=32).
module tb_systolic_result_drain;
  localparam int N    = 4;
  localparam int Accw = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  logic [Accw-1:0]   cur_m  [N][N];
  logic [Accw-1:0]   snap_m [N][N];
  logic [N*Accw-1:0] seen_row2;

  systolic_result_drain_if #(.N(N), .Accw(Accw)) bus ();

  systolic_result_drain #(.N(N), .W(8), .Accw(Accw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_acc();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.acc_in[(i*N+j)*Accw +: Accw] = cur_m[i][j];
  endtask

  task automatic set_pattern(input int base);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cur_m[i][j] = Accw'(base + i*N + j);
    drive_acc();
  endtask

  function automatic logic [N*Accw-1:0] row_of(input int r);
    logic [N*Accw-1:0] res;
    logic [Accw-1:0]   v;
    res = '0;
    for (int j = 0; j < N; j++) begin
      v = snap_m[r][j];
`ifdef SYSTOLIC_DRAIN_RELU_EN
      if (v[Accw-1]) v = '0;
`endif
      res[j*Accw +: Accw] = v;
    end
    return res;
  endfunction

  // Pulse start from IDLE and record what the bench expects to be captured.
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    check("drop_idle", bus.drop, 1'b0);
    check("busy_idle", bus.busy, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        snap_m[i][j] = cur_m[i][j];
  endtask

  // Follow the stream after capture; rpat bit k is row_ready in stream cycle k.
  task automatic drain(input logic [15:0] rpat, input int drop_at, input bit poison);
    int r;
    int k;
    r = 0;
    k = 0;
    while (r < N && k < 40) begin
      @(negedge clk);
      bus.row_ready = rpat[k%16];
      bus.start     = (k == drop_at);
      if (poison && k == 0) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            cur_m[i][j] = 32'd7;
        drive_acc();
      end
      #1;
      check("acc_clr", bus.acc_clr, (k == 0));
      check("valid", bus.row_valid, 1'b1);
      check("busy", bus.busy, 1'b1);
      check("no_done", bus.done, 1'b0);
      check("idx", bus.row_idx, r);
      check("data", bus.row_data, row_of(r));
      check("last", bus.row_last, (r == N-1));
      if (k == drop_at) check("drop_send", bus.drop, 1'b1);
      if (r == 2) seen_row2 = bus.row_data;
      if (bus.row_ready) r++;
      k++;
    end
    if (r < N) check("stream_timeout", r, N);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("done", bus.done, 1'b1);
    check("busy_done", bus.busy, 1'b1);
    check("valid_off", bus.row_valid, 1'b0);
    check("data_zero", bus.row_data, '0);
    $display("stream ready=%h drop_at=%0d poison=%0d accepts=%0d cycles=%0d", rpat, drop_at, poison, r, k);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"}, bus.row_valid, 1'b0);
    check({pfx, "_busy"},  bus.busy, 1'b0);
    check({pfx, "_done"},  bus.done, 1'b0);
    check({pfx, "_clr"},   bus.acc_clr, 1'b0);
    check({pfx, "_idx"},   bus.row_idx, '0);
    check({pfx, "_last"},  bus.row_last, 1'b0);
    check({pfx, "_data"},  bus.row_data, '0);
    check({pfx, "_drop"},  bus.drop, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.row_ready = 1'b0;
    bus.acc_in = '0;
    seen_row2 = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    $display("reset state checked");
    rst = 1'b1;

    // 1: ramp pattern, ready held high
    set_pattern(0);
    bus.row_ready = 1'b1;
    do_start();
    drain(16'hFFFF, -1, 1'b0);
    check("row2_hand", seen_row2, {32'd11, 32'd10, 32'd9, 32'd8});
    @(negedge clk);
    #1;
    check("idle_busy", bus.busy, 1'b0);
    check("idle_done", bus.done, 1'b0);

    // 2: stalls 1,0,0,1,0,1,0,1
    set_pattern(20);
    do_start();
    drain(16'hAAA9, -1, 1'b0);

    // 3: acc_in overwritten after capture, start during SEND dropped
    set_pattern(40);
    do_start();
    drain(16'hFFFF, 1, 1'b1);

    // 4: negative values, RELU clamp or passthrough
    set_pattern(0);
    cur_m[1][1] = 32'hFFFF_FFFB;
    cur_m[0][0] = 32'h8000_0000;
    drive_acc();
    do_start();
    drain(16'hFFFF, -1, 1'b0);

    // 5: reset during beat 2, then a fresh stream
    set_pattern(100);
    do_start();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.row_ready = 1'b1;
      #1;
      check("pre_rst_idx", bus.row_idx, k);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
    $display("mid-stream reset checked");
    rst = 1'b1;
    set_pattern(200);
    do_start();
    drain(16'hFFFF, -1, 1'b0);

    // 6: start held high for 10 cycles
    set_pattern(60);
    bus.row_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.start = (k < 10);
      #1;
      if (k == 0 || k == 6) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            snap_m[i][j] = cur_m[i][j];
      end
      check("hold_drop", bus.drop, ((k >= 1 && k <= 5) || (k >= 7 && k <= 9)));
      check("hold_busy", bus.busy, ((k >= 1 && k <= 5) || (k >= 7)));
      check("hold_done", bus.done, (k == 5 || k == 11));
      check("hold_clr", bus.acc_clr, (k == 1 || k == 7));
      if (k >= 7 && k <= 10) begin
        check("hold_idx", bus.row_idx, k - 7);
        check("hold_data", bus.row_data, row_of(k - 7));
      end
      $display("hold cycle %0d start=%0d drop=%0d busy=%0d done=%0d", k, bus.start, bus.drop, bus.busy, bus.done);
    end
    bus.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
